data_sync_multi: RTL

Multi-channel destination-side bus synchronizer for the CDC/power subsystem. Each of NUM_CH channels carries a data bus qualified by an enable from a foreign clock domain. Each channel's enable is synchronized through an NUM_STAGES flop chain. On an enable event, the block captures the bus, emits a one-cycle pulse and returns an acknowledge toggle to the source. Captured words are merged into a single valid/ready stream by a round-robin arbiter, with per-channel overrun detection.

---
 rtl/data_sync_multi.sv | 141 ++++++++++++++
 1 files changed

// File: rtl/data_sync_multi.sv
// Multi-channel destination-side enable/bus synchronizer with per-channel capture,
// acknowledge toggle, sticky overrun detection and a round-robin merged output stream.
module data_sync_multi #(
    parameter int BUS_WIDTH  = 8,
    parameter int NUM_STAGES = 2,
    parameter int NUM_CH     = 2,
    parameter int EDGE_MODE  = 0,
    parameter int CH_W       = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic                        CLK,
    input  logic                        RST,
    input  logic [NUM_CH*BUS_WIDTH-1:0] UNSYNC_BUS,
    input  logic [NUM_CH-1:0]           BUS_ENABLE,
    output logic [NUM_CH*BUS_WIDTH-1:0] SYNC_BUS,
    output logic [NUM_CH-1:0]           ENABLE_PULSE,
    output logic [NUM_CH-1:0]           ACK_TGL,
    output logic [BUS_WIDTH-1:0]        OUT_DATA,
    output logic [CH_W-1:0]             OUT_CH,
    output logic                        OUT_VALID,
    input  logic                        OUT_READY,
    output logic [NUM_CH-1:0]           OVERRUN,
    input  logic                        CLR_OVR
);

    logic [NUM_CH-1:0]           sync_q [NUM_STAGES];
    logic [NUM_CH-1:0]           hist_q;
    logic [NUM_CH-1:0]           sync_s;
    logic [NUM_CH-1:0]           evt;

    logic [NUM_CH*BUS_WIDTH-1:0] bus_q, bus_d;
    logic [NUM_CH-1:0]           pulse_q;
    logic [NUM_CH-1:0]           ack_q, ack_d;
    logic [NUM_CH-1:0]           pend_q, pend_d;
    logic [NUM_CH-1:0]           ovr_q, ovr_d;
    logic [NUM_CH-1:0]           grant;

    logic [BUS_WIDTH-1:0]        dat_q, dat_d;
    logic [CH_W-1:0]             ch_q, ch_d;
    logic [CH_W-1:0]             last_q, last_d;
    logic                        vld_q, vld_d;

    logic [CH_W-1:0]             gidx;
    logic [CH_W-1:0]             cidx;
    logic                        found;
    logic                        load;
    int                          cand;

    // Stage boundary: enable synchronizer chain plus one history flop for edge detection
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int k = 0; k < NUM_STAGES; k++) sync_q[k] <= '0;
            hist_q <= '0;
        end else begin
            sync_q[0] <= BUS_ENABLE;
            for (int k = 1; k < NUM_STAGES; k++) sync_q[k] <= sync_q[k-1];
            hist_q <= sync_q[NUM_STAGES-1];
        end
    end

    assign sync_s = sync_q[NUM_STAGES-1];
    assign evt    = (EDGE_MODE != 0) ? (sync_s ^ hist_q) : (sync_s & ~hist_q);

    always_comb begin
        bus_d = bus_q;
        for (int i = 0; i < NUM_CH; i++) begin
            if (evt[i]) bus_d[i*BUS_WIDTH +: BUS_WIDTH] = UNSYNC_BUS[i*BUS_WIDTH +: BUS_WIDTH];
        end
        ack_d = ack_q ^ evt;
    end

    // Round-robin search starts one past the last granted channel
    always_comb begin
        gidx  = '0;
        cidx  = '0;
        cand  = 0;
        found = 1'b0;
        for (int j = 0; j < NUM_CH; j++) begin
            cand = int'(last_q) + 1 + j;
            if (cand >= NUM_CH) cand = cand - NUM_CH;
            cidx = CH_W'(cand);
            if (!found && pend_q[cidx]) begin
                found = 1'b1;
                gidx  = cidx;
            end
        end
        load  = (!vld_q || OUT_READY) && found;
        grant = '0;
        if (load) grant[gidx] = 1'b1;

        dat_d  = dat_q;
        ch_d   = ch_q;
        vld_d  = vld_q;
        last_d = last_q;
        if (load) begin
            // Takes the pre-edge word, so a same-cycle capture on this channel stays pending
            dat_d  = bus_q[gidx*BUS_WIDTH +: BUS_WIDTH];
            ch_d   = gidx;
            vld_d  = 1'b1;
            last_d = gidx;
        end else if (vld_q && OUT_READY) begin
            vld_d = 1'b0;
        end

        pend_d = (pend_q & ~grant) | evt;
        ovr_d  = (ovr_q & ~{NUM_CH{CLR_OVR}}) | (evt & pend_q & ~grant);
    end

    // Stage boundary: capture registers and merged output stream
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            bus_q   <= '0;
            pulse_q <= '0;
            ack_q   <= '0;
            pend_q  <= '0;
            ovr_q   <= '0;
            dat_q   <= '0;
            ch_q    <= '0;
            vld_q   <= 1'b0;
            last_q  <= CH_W'(NUM_CH - 1);
        end else begin
            bus_q   <= bus_d;
            pulse_q <= evt;
            ack_q   <= ack_d;
            pend_q  <= pend_d;
            ovr_q   <= ovr_d;
            dat_q   <= dat_d;
            ch_q    <= ch_d;
            vld_q   <= vld_d;
            last_q  <= last_d;
        end
    end

    assign SYNC_BUS     = bus_q;
    assign ENABLE_PULSE = pulse_q;
    assign ACK_TGL      = ack_q;
    assign OUT_DATA     = dat_q;
    assign OUT_CH       = ch_q;
    assign OUT_VALID    = vld_q;
    assign OVERRUN      = ovr_q;

endmodule
